monitor_init_sequencer: RTL
===========================

# monitor_init_sequencer

Sequences post-configuration bring-up of the fabric on PolarFire. It consumes the device init-monitor status flags (fabric POR, device init done, HSIO bank 0/1 calibration status), synchronises them into the fabric clock domain and releases a chain of staged active-low resets to downstream logic. It reports ready and fault status, and re-asserts every stage reset as soon as any prerequisite drops.

## Interface
- N_STAGES, 4: number of staged reset outputs, 1..8.
- STAGE_GAP, 16: clock cycles between consecutive stage releases, ≥1.
- TIMEOUT_CYCLES, 1000000: watchdog limit in cycles, ≥2 (used only with the timeout feature).
- CLK  in  1  fabric clock.
- RESET  in  1  synchronous, active-high reset.
- FABRIC_POR_N  in  1  async, init-monitor fabric POR (high = released).
- DEVICE_INIT_DONE  in  1  async, device init complete.
- BANK_0_CALIB_STATUS  in  1  async, HSIO bank 0 calibrated.
- BANK_1_CALIB_STATUS  in  1  async, HSIO bank 1 calibrated.
- FAULT_CLEAR  in  1  sync pulse; leaves FAULT.
- STAGE_RESET_N  out  N_STAGES  staged resets, bit 0 released first.
- READY  out  1  all stages released.
- FAULT  out  1  watchdog expired.
- STATE  out  3  current state encoding, for debug.

## Operation
- All four async inputs pass through a 2-flop synchroniser each. These flops reset to 0 on RESET.
- States and encodings: WAIT_POR=0, WAIT_INIT=1, WAIT_CALIB=2, RELEASE=3, RUN=4, FAULT_ST=5.
- WAIT_POR -> WAIT_INIT when synced POR_N=1.
- WAIT_INIT -> WAIT_CALIB when synced INIT_DONE=1.
- WAIT_CALIB -> RELEASE when both synced CALIB bits are 1.
- RELEASE: the gap counter counts 0..STAGE_GAP-1.
  - On each terminal count, the next stage bit is set (bit k rises exactly (k+1)·STAGE_GAP cycles after RELEASE entry).
  - After bit N_STAGES-1 is set, the state moves to RUN.
- RUN: READY=1.
- Prerequisite-loss rule, applies in every state except FAULT_ST:
  - The state has a prerequisite (POR for WAIT_INIT and later; INIT for WAIT_CALIB and later; CALIB for RELEASE and RUN).
  - If any such synced prerequisite drops, next cycle: the state returns to the earliest state whose condition is now unmet, all STAGE_RESET_N bits go to 0, and READY goes to 0.
- Simultaneous loss and stage release in the same cycle: the loss wins, and no bit is set.
- Stage bits are set only in increasing order. Bit k is never high while bit k-1 is low.
- FAULT_ST: all stage resets are held asserted and FAULT=1. A FAULT_CLEAR pulse moves the state to WAIT_POR and clears FAULT.
- FAULT_CLEAR outside FAULT_ST is ignored.

## Timing
- Reset values: STAGE_RESET_N=0, READY=0, FAULT=0, STATE=0. The gap counter and the watchdog are zero.
- All outputs are registered.
- Input-to-state latency: 2 cycles of synchroniser plus 1 cycle of FSM register.
- The gap counter clears on every RELEASE entry.
- READY rises in the same cycle as the last STAGE_RESET_N bit rises.
- Worst-case release duration is N_STAGES·STAGE_GAP cycles.
- Loss of a prerequisite in RUN: STAGE_RESET_N becomes all 0 and READY becomes 0 on the third edge after the raw input drops.
- RESET asserted mid-sequence returns everything to the reset values on the next edge, regardless of state.

## Configuration
- INIT_SEQ_TIMEOUT_EN defined:
  - A watchdog counter, width $clog2(TIMEOUT_CYCLES+1), counts every cycle spent in WAIT_POR, WAIT_INIT or WAIT_CALIB.
  - It clears on entry to RELEASE and on exit from FAULT_ST.
  - Reaching TIMEOUT_CYCLES forces FAULT_ST.
- INIT_SEQ_TIMEOUT_EN undefined:
  - The watchdog logic is absent and FAULT_ST is unreachable.
  - FAULT ties to 0 and FAULT_CLEAR is unused.

## Structure
- Package monitor_init_seq_pkg holds:
  - the state enum (3-bit, encodings above);
  - the synchroniser depth constant SYNC_STAGES=2.
- One sub-module: monitor_sync_2ff, a single-bit 2-flop synchroniser with synchronous active-high reset. It is instantiated four times.

## Test plan
- Ordered bring-up: N_STAGES=4, STAGE_GAP=16; POR, INIT and both CALIB rise 10 cycles apart.
  - RELEASE entered 3 cycles after the last CALIB.
  - Bits 0..3 rise at +16, +32, +48 and +64.
  - READY=1 at +64 and STATE=4.
- Out-of-order inputs: CALIB and INIT high before POR.
  - The state stays 0 until POR arrives, then steps 0 -> 1 -> 2 -> 3 on consecutive cycles.
- Mid-release loss: BANK_1_CALIB_STATUS drops after bit 1 is set.
  - 3 cycles later, STAGE_RESET_N=0, STATE=2 and READY=0.
  - Restoring CALIB restarts the release from bit 0 with a fresh gap count.
- POR loss in RUN: FABRIC_POR_N drops.
  - STATE=0 and all outputs 0 within 3 cycles.
- Timeout (macro on, TIMEOUT_CYCLES=100): hold INIT_DONE low.
  - FAULT=1 and STATE=5 at cycle 100 after reset release.
  - FAULT_CLEAR returns STATE=0 and FAULT=0; the next timeout occurs 100 cycles later.
- Reset mid-release: assert RESET while bit 2 is high.
  - Next edge: all outputs 0 and STATE=0.
  - A full sequence repeats correctly after RESET deasserts.

Source files
------------

// File: rtl/monitor_init_sequencer_pkg.sv
// Shared types for the init-monitor bring-up sequencer: FSM state encoding
// and synchroniser depth.
package monitor_init_seq_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        WAIT_POR   = 3'd0,
        WAIT_INIT  = 3'd1,
        WAIT_CALIB = 3'd2,
        RELEASE    = 3'd3,
        RUN        = 3'd4,
        FAULT_ST   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/monitor_init_sequencer_if.sv
// Status inputs and staged-reset/status outputs of the bring-up sequencer.
// The master side drives the init-monitor flags; the slave side is the sequencer.
interface monitor_init_sequencer_if #(
    parameter int N_STAGES = 4
);
    logic                FABRIC_POR_N;
    logic                DEVICE_INIT_DONE;
    logic                BANK_0_CALIB_STATUS;
    logic                BANK_1_CALIB_STATUS;
    logic                FAULT_CLEAR;
    logic [N_STAGES-1:0] STAGE_RESET_N;
    logic                READY;
    logic                FAULT;
    logic [2:0]          STATE;

    modport master (
        output FABRIC_POR_N, DEVICE_INIT_DONE, BANK_0_CALIB_STATUS,
               BANK_1_CALIB_STATUS, FAULT_CLEAR,
        input  STAGE_RESET_N, READY, FAULT, STATE
    );

    modport slave (
        input  FABRIC_POR_N, DEVICE_INIT_DONE, BANK_0_CALIB_STATUS,
               BANK_1_CALIB_STATUS, FAULT_CLEAR,
        output STAGE_RESET_N, READY, FAULT, STATE
    );
endinterface

// File: rtl/monitor_sync_2ff.sv
// Single-bit multi-flop synchroniser for an asynchronous level into clk,
// cleared to 0 by the synchronous active-high reset.
module monitor_sync_2ff
    import monitor_init_seq_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (srst) sync_q <= '0;
        else      sync_q <= sync_d;
    end

    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/monitor_init_sequencer.sv
// Post-configuration bring-up sequencer: waits for POR, init done and bank
// calibration, then releases staged resets. Optional watchdog: INIT_SEQ_TIMEOUT_EN.
module monitor_init_sequencer
    import monitor_init_seq_pkg::*;
#(
    parameter int N_STAGES       = 4,
    parameter int STAGE_GAP      = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic CLK,
    input logic RESET,
    monitor_init_sequencer_if.slave bus
);
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);

    logic [3:0] raw_in;
    logic [3:0] sync_out;

    assign raw_in = {bus.BANK_1_CALIB_STATUS, bus.BANK_0_CALIB_STATUS,
                     bus.DEVICE_INIT_DONE, bus.FABRIC_POR_N};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        monitor_sync_2ff u_sync (
            .clk  (CLK),
            .srst (RESET),
            .d    (raw_in[gi]),
            .q    (sync_out[gi])
        );
    end

    logic por_ok, init_ok, calib_ok;
    assign por_ok   = sync_out[0];
    assign init_ok  = sync_out[1];
    assign calib_ok = sync_out[2] & sync_out[3];

    seq_state_e          state_q, state_d;
    logic [N_STAGES-1:0] stage_q, stage_d, stage_next;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                ready_q, ready_d;
    logic                fault_q, fault_d;

`ifdef INIT_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_fault_clear;
    assign unused_fault_clear = bus.FAULT_CLEAR;
`endif

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        gap_d   = '0;
        // Stage vector is a thermometer code, so OR-ing in (x+1) lights the next bit.
        stage_next = stage_q | (stage_q + N_STAGES'(1));

        case (state_q)
            WAIT_POR: begin
                if (por_ok) state_d = WAIT_INIT;
            end
            WAIT_INIT: begin
                if (!por_ok)      state_d = WAIT_POR;
                else if (init_ok) state_d = WAIT_CALIB;
            end
            WAIT_CALIB: begin
                if (!por_ok)       state_d = WAIT_POR;
                else if (!init_ok) state_d = WAIT_INIT;
                else if (calib_ok) state_d = RELEASE;
            end
            RELEASE, RUN: begin
                if (!por_ok)        state_d = WAIT_POR;
                else if (!init_ok)  state_d = WAIT_INIT;
                else if (!calib_ok) state_d = WAIT_CALIB;
                else if (state_q == RELEASE) begin
                    if (gap_q == GAP_LAST) begin
                        stage_d = stage_next;
                        if (stage_next[N_STAGES-1]) state_d = RUN;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            FAULT_ST: begin
`ifdef INIT_SEQ_TIMEOUT_EN
                if (bus.FAULT_CLEAR) state_d = WAIT_POR;
`else
                state_d = WAIT_POR;
`endif
            end
            default: state_d = WAIT_POR;
        endcase

`ifdef INIT_SEQ_TIMEOUT_EN
        wd_d = '0;
        if (state_q == WAIT_POR || state_q == WAIT_INIT || state_q == WAIT_CALIB) begin
            wd_d = wd_q + WD_W'(1);
            if (wd_d == WD_W'(TIMEOUT_CYCLES)) state_d = FAULT_ST;
        end
`endif

        // Any non-releasing destination (loss, fault, waits) asserts every stage.
        if (state_d != RELEASE && state_d != RUN) stage_d = '0;
        ready_d = (state_d == RUN);
        fault_d = (state_d == FAULT_ST);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= WAIT_POR;
            stage_q <= '0;
            gap_q   <= '0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

`ifdef INIT_SEQ_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RESET) wd_q <= '0;
        else       wd_q <= wd_d;
    end
    assign bus.FAULT = fault_q;
`else
    logic unused_fault_q;
    assign unused_fault_q = fault_q;
    assign bus.FAULT = 1'b0;
`endif

    assign bus.STAGE_RESET_N = stage_q;
    assign bus.READY         = ready_q;
    assign bus.STATE         = state_q;
endmodule
